// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//   Converts ball-logic goal events into the registered per-player scores that
//   the game-state decoder compares against its win count. It also owns the
//   post-goal serve hold-off and the serve direction, and freezes scoring once
//   the decoder reports a winner.
//
// Parameters
//   WIN_SCORE  score at which counting saturates (matches decoder win count)
//   HOLD_MS    serve hold-off after a goal, in clk_1ms ticks (>= 1)
//   HOLD_W     hold counter width, 2**HOLD_W > HOLD_MS
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   clk_1ms    in   1 ms divider level; rising edge detected in clk domain
//   goal_p1    in   P1 scored (level, asynchronous to clk)
//   goal_p2    in   P2 scored (level, asynchronous to clk)
//   gstate     in   decoder state: 00 begin, 01 playing, 10 P1 won, 11 P2 won
//   p1_score   out  player 1 score (registered)
//   p2_score   out  player 2 score (registered)
//   serve_hold out  1 = ball frozen at centre
//   serve_dir  out  0 = next serve toward P1, 1 = toward P2
//   goal_flag  out  one-cycle pulse when a goal is accepted
//
// Build option
//   SERVE_ALTERNATE_EN  when defined, serve_dir toggles on every accepted goal
//                       instead of pointing at the conceding player.
// -----------------------------------------------------------------------------
module score_keeper #(
  parameter int WIN_SCORE = 5,
  parameter int HOLD_MS   = 1000,
  parameter int HOLD_W    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1ms,
  input  logic       goal_p1,
  input  logic       goal_p2,
  input  logic [1:0] gstate,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       serve_hold,
  output logic       serve_dir,
  output logic       goal_flag
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam logic [3:0]        WIN_Q     = 4'(WIN_SCORE);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MS - 1);

  // Bit order in the sync chain: {clk_1ms, goal_p2, goal_p1}
  logic [2:0] s1_q, s2_q;
  logic [2:0] evt;
  logic       ev_p1, ev_p2, ev_tick;

  state_e            state_q, state_d;
  logic [3:0]        p1_q, p1_d, p2_q, p2_d;
  logic              dir_q, dir_d;
  logic              flag_q, flag_d;
  logic              hold_q, hold_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  // One sync flop plus one delay flop; a rising edge is s1 & ~s2, so a level
  // held high yields exactly one event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {clk_1ms, goal_p2, goal_p1};
      s2_q <= s1_q;
    end
  end

  assign evt     = s1_q & ~s2_q;
  assign ev_p1   = evt[0];
  assign ev_p2   = evt[1];
  assign ev_tick = evt[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      dir_q   <= 1'b0;
      flag_q  <= 1'b0;
      hold_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      dir_q   <= dir_d;
      flag_q  <= flag_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    dir_d   = dir_q;
    flag_d  = 1'b0;
    cnt_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (gstate == 2'b01) state_d = ST_PLAY;
      end

      ST_PLAY: begin
        // Decoder state changes win over a goal arriving in the same cycle.
        if (gstate == 2'b00) begin
          state_d = ST_IDLE;
        end else if (gstate[1]) begin
          state_d = ST_OVER;
        end else if (ev_p1 ^ ev_p2) begin
          // Simultaneous goals cancel out: the XOR filters them.
          flag_d  = 1'b1;
          state_d = ST_HOLD;
          if (ev_p1) begin
            if (p1_q < WIN_Q) p1_d = p1_q + 4'd1;
          end else begin
            if (p2_q < WIN_Q) p2_d = p2_q + 4'd1;
          end
`ifdef SERVE_ALTERNATE_EN
          dir_d = ~dir_q;
`else
          // Serve toward the player who conceded.
          dir_d = ev_p1;
`endif
        end
      end

      ST_HOLD: begin
        cnt_d = cnt_q;
        // A reported winner takes priority over hold-off expiry.
        if (gstate[1]) begin
          state_d = ST_OVER;
          cnt_d   = '0;
        end else if (gstate == 2'b00) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (ev_tick) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_OVER: begin
        if (gstate == 2'b00) begin
          state_d = ST_IDLE;
          p1_d    = '0;
          p2_d    = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Registered so serve_hold tracks the state register exactly.
    hold_d = (state_d != ST_PLAY);
  end

  assign p1_score   = p1_q;
  assign p2_score   = p2_q;
  assign serve_hold = hold_q;
  assign serve_dir  = dir_q;
  assign goal_flag  = flag_q;

endmodule
